// File: rtl/evm_controller.sv
// Electronic voting machine controller: voter sessions, three saturating vote
// counters and a registered result/winner display once polling is closed.
module evm_controller #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch_on_evm,
  input  logic             candidate_ready,
  input  logic             vote_candidate_1,
  input  logic             vote_candidate_2,
  input  logic             vote_candidate_3,
  input  logic             voting_session_done,
  input  logic [1:0]       display_results,
  input  logic             display_winner,
  output logic [1:0]       candidate_name,
  output logic             invalid_results,
  output logic [WIDTH-1:0] results,
  output logic             voting_in_progress,
  output logic             voting_done
);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_WAIT_VOTER = 3'd1,
    S_WAIT_VOTE  = 3'd2,
    S_VOTED      = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  // The timer counts the cycles already spent in WAIT_VOTE: 0 .. TIMEOUT-1.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CMAX  = '1;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;

  logic [1:0]       name_d;
  logic             inv_d;
  logic [WIDTH-1:0] res_d;
  logic             vip_d;
  logic             vdone_d;

  logic [2:0]       btn;
  logic [WIDTH-1:0] max12, maxv;
  logic [1:0]       n_at_max;

  assign btn = {vote_candidate_3, vote_candidate_2, vote_candidate_1};

  // State, timer and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      timer_q <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    c3_d    = c3_q;
    case (state_q)
      S_OFF: begin
        if (switch_on_evm) state_d = S_WAIT_VOTER;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        if (!switch_on_evm) begin
          state_d = S_OFF;
        end else begin
          case (state_q)
            S_WAIT_VOTER: begin
              if (voting_session_done) begin
                state_d = S_DONE;
              end else if (candidate_ready) begin
                state_d = S_WAIT_VOTE;
                timer_d = '0;
              end
            end
            S_WAIT_VOTE: begin
              // A vote on the final allowed cycle still counts.
              if (btn == 3'b001 || btn == 3'b010 || btn == 3'b100) begin
                state_d = S_VOTED;
                if (btn[0] && c1_q != CMAX) c1_d = c1_q + 1'b1;
                if (btn[1] && c2_q != CMAX) c2_d = c2_q + 1'b1;
                if (btn[2] && c3_q != CMAX) c3_d = c3_q + 1'b1;
              end else if (timer_q == TLAST) begin
                state_d = S_WAIT_VOTER;
              end else begin
                timer_d = timer_q + 1'b1;
              end
            end
            S_VOTED: begin
              if (candidate_ready && btn == 3'b000) state_d = S_WAIT_VOTER;
            end
            default: state_d = S_OFF;
          endcase
        end
      end
    endcase
  end

  // Winner search over the post-edge counter values
  always_comb begin
    max12    = (c1_d >= c2_d) ? c1_d : c2_d;
    maxv     = (max12 >= c3_d) ? max12 : c3_d;
    n_at_max = 2'(c1_d == maxv) + 2'(c2_d == maxv) + 2'(c3_d == maxv);
  end

  // Outputs, computed from the next state so they register on the same edge
  always_comb begin
    name_d  = 2'b00;
    inv_d   = 1'b0;
    res_d   = '0;
    vip_d   = (state_d == S_WAIT_VOTE) || (state_d == S_VOTED);
    vdone_d = (state_d == S_DONE);
    if (state_d == S_DONE) begin
      if (display_winner) begin
        res_d = maxv;
        if (maxv == '0 || n_at_max != 2'd1) begin
          inv_d = 1'b1;
        end else if (c1_d == maxv) begin
          name_d = 2'b01;
        end else if (c2_d == maxv) begin
          name_d = 2'b10;
        end else begin
          name_d = 2'b11;
        end
      end else begin
        case (display_results)
          2'b00:   begin name_d = 2'b01; res_d = c1_d; end
          2'b01:   begin name_d = 2'b10; res_d = c2_d; end
          2'b10:   begin name_d = 2'b11; res_d = c3_d; end
          default: inv_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      candidate_name     <= 2'b00;
      invalid_results    <= 1'b0;
      results            <= '0;
      voting_in_progress <= 1'b0;
      voting_done        <= 1'b0;
    end else begin
      candidate_name     <= name_d;
      invalid_results    <= inv_d;
      results            <= res_d;
      voting_in_progress <= vip_d;
      voting_done        <= vdone_d;
    end
  end

endmodule
